// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: issues one wide operation to an external N-bit ALU,
// one word per cycle starting with the least significant word. Carry or borrow
// is chained between words, and the wide result is assembled word by word.
//
// Handshake: start is sampled only in IDLE, and a start seen at a rising edge
// in IDLE is accepted at that edge. busy is high for the WORDS cycles of RUN.
// done is a single-cycle pulse in DONE, and result/cout are valid in that cycle.
// There is no back-pressure: any start that arrives in RUN or DONE is dropped.
module alu_word_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_cb_in,
  output logic [2:0]           alu_mode,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_cb_out,
  output logic [1:0]           dbg_state
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] M_ADD = 3'b000;
  localparam logic [2:0] M_SUB = 3'b001;
  localparam logic [2:0] M_INC = 3'b110;
  localparam logic [2:0] M_DEC = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      mode_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    result_q;
  logic            cout_q;

  logic            is_logic;
  logic            is_incdec;
  logic            last_word;
  logic [N-1:0]    a_word;
  logic [N-1:0]    b_word;

  // Decode the latched op code and select the current words from the operands.
  always_comb begin
    is_logic  = !((mode_q == M_ADD) || (mode_q == M_SUB) ||
                  (mode_q == M_INC) || (mode_q == M_DEC));
    is_incdec = (mode_q == M_INC) || (mode_q == M_DEC);
    last_word = (idx_q == IW'(WORDS - 1));
    a_word    = '0;
    b_word    = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        a_word = a_q[k*N +: N];
        b_word = b_q[k*N +: N];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and ALU-facing outputs (zero outside RUN).
  always_comb begin
    state_d   = state_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_cb_in = 1'b0;
    alu_mode  = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        alu_a     = a_word;
        // inc/dec are issued as add/sub of zero, with the preloaded carry of 1.
        alu_b     = is_incdec ? '0 : b_word;
        alu_cb_in = carry_q;
        if (mode_q == M_INC)      alu_mode = M_ADD;
        else if (mode_q == M_DEC) alu_mode = M_SUB;
        else                      alu_mode = mode_q;
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latch, word index, carry chain and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 3'b000;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= op_a;
            b_q    <= op_b;
            mode_q <= mode;
            idx_q  <= '0;
            cout_q <= 1'b0;
            if ((mode == M_ADD) || (mode == M_SUB))      carry_q <= cin;
            else if ((mode == M_INC) || (mode == M_DEC)) carry_q <= 1'b1;
            else                                         carry_q <= 1'b0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) result_q[k*N +: N] <= alu_result;
          end
          carry_q <= is_logic ? 1'b0 : alu_cb_out;
          if (last_word) cout_q <= is_logic ? 1'b0 : alu_cb_out;
          else           idx_q  <= idx_q + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer: supplies a combinational N-bit ALU and checks
// wide results against whole-word arithmetic.
module tb_alu_word_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] result;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_cb_in, alu_cb_out;
  logic [2:0]   alu_mode;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Per-word traces of what the sequencer issued during RUN.
  logic [W-1:0] exp_q[$];
  logic         cb_tr[WORDS];
  logic [2:0]   md_tr[WORDS];
  logic [N-1:0] b_tr[WORDS];

  alu_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cb_in(alu_cb_in), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_cb_out(alu_cb_out), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // External N-bit ALU.
  logic [N:0] alu_t;
  always_comb begin
    alu_t      = '0;
    alu_result = '0;
    alu_cb_out = 1'b0;
    case (alu_mode)
      3'b000: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b} + alu_cb_in; alu_result = alu_t[N-1:0]; alu_cb_out = alu_t[N]; end
      3'b001: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b} - alu_cb_in; alu_result = alu_t[N-1:0]; alu_cb_out = alu_t[N]; end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: begin alu_t = {1'b0, alu_a} + 1; alu_result = alu_t[N-1:0]; alu_cb_out = alu_t[N]; end
      default: begin alu_t = {1'b0, alu_a} - 1; alu_result = alu_t[N-1:0]; alu_cb_out = alu_t[N]; end
    endcase
  end

  // Reference: the whole operation done in W-bit arithmetic.
  function automatic void ref_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, output logic [W-1:0] r, output logic co);
    logic [W:0] t;
    t  = '0;
    co = 1'b0;
    case (m)
      3'b000: begin t = {1'b0, a} + {1'b0, b} + (W+1)'(ci); r = t[W-1:0]; co = t[W]; end
      3'b001: begin t = {1'b0, a} - {1'b0, b} - (W+1)'(ci); r = t[W-1:0]; co = t[W]; end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~a;
      3'b110: begin r = a + 1'b1; co = (a == {W{1'b1}}); end
      default: begin r = a - 1'b1; co = (a == '0); end
    endcase
  endfunction

  // Driver: issue one op, scramble inputs after acceptance, wait for done.
  // lat = cycles from accepting edge to done (0 on timeout).
  task automatic do_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] res, output logic co,
                       output int lat, output int bcnt);
    lat = 0; bcnt = 0; res = 'x; co = 1'bx;
    @(negedge clk);
    start = 1'b1; mode = m; op_a = a; op_b = b; cin = ci;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); mode = 3'($urandom); cin = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (busy) begin
        if (bcnt < WORDS) begin
          cb_tr[bcnt] = alu_cb_in; md_tr[bcnt] = alu_mode; b_tr[bcnt] = alu_b;
        end
        bcnt++;
      end
      if (done) begin
        lat = c; res = result; co = cout;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_cmp++; if ({alu_a, alu_b, alu_cb_in, alu_mode} !== '0)
      begin n_err++; $display("FAIL reset_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_cb_in, alu_mode); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({alu_a, alu_b, alu_cb_in, alu_mode} !== '0)
      begin n_err++; $display("FAIL idle_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_cb_in, alu_mode); end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic co; int lat, bc;
    do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, r, co, lat, bc);
    n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL add_result got=%h exp=0000", r); end
    n_cmp++; if (co !== 1'b1) begin n_err++; $display("FAIL add_cout got=%b exp=1", co); end
    n_cmp++; if (lat != WORDS + 1) begin n_err++; $display("FAIL add_latency got=%0d exp=%0d", lat, WORDS + 1); end
    n_cmp++; if (bc != WORDS) begin n_err++; $display("FAIL add_busy_cycles got=%0d exp=%0d", bc, WORDS); end
    n_cmp++; if ({cb_tr[0], cb_tr[1], cb_tr[2], cb_tr[3]} !== 4'b0111)
      begin n_err++; $display("FAIL add_cb_chain got=%b%b%b%b exp=0111", cb_tr[0], cb_tr[1], cb_tr[2], cb_tr[3]); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL result_hold got=%h exp=0000", result); end
  endtask

  task automatic test_sub();
    logic [W-1:0] r; logic co; int lat, bc;
    do_op(3'b001, 16'h1000, 16'h0001, 1'b0, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'h0FFF, 1'b0}) begin n_err++; $display("FAIL sub1 got=%h/%b exp=0fff/0", r, co); end
    do_op(3'b001, 16'h0000, 16'h0001, 1'b0, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL sub2 got=%h/%b exp=ffff/1", r, co); end
  endtask

  task automatic test_inc_dec();
    logic [W-1:0] r; logic co; int lat, bc;
    do_op(3'b110, 16'hFFFF, 16'h5A5A, 1'b0, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL inc got=%h/%b exp=0000/1", r, co); end
    for (int k = 0; k < WORDS; k++) begin
      n_cmp++; if ({md_tr[k], b_tr[k]} !== {3'b000, 4'h0})
        begin n_err++; $display("FAIL inc_issue w%0d got=%b/%h exp=000/0", k, md_tr[k], b_tr[k]); end
    end
    do_op(3'b111, 16'h0100, 16'hFFFF, 1'b1, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'h00FF, 1'b0}) begin n_err++; $display("FAIL dec got=%h/%b exp=00ff/0", r, co); end
    n_cmp++; if ({md_tr[0], b_tr[0]} !== {3'b001, 4'h0})
      begin n_err++; $display("FAIL dec_issue got=%b/%h exp=001/0", md_tr[0], b_tr[0]); end
  endtask

  task automatic test_logic();
    logic [W-1:0] r; logic co; int lat, bc;
    do_op(3'b100, 16'hA5A5, 16'h0FF0, 1'b1, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'hAA55, 1'b0}) begin n_err++; $display("FAIL xor got=%h/%b exp=aa55/0", r, co); end
    do_op(3'b101, 16'h1234, 16'hFFFF, 1'b1, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'hEDCB, 1'b0}) begin n_err++; $display("FAIL not got=%h/%b exp=edcb/0", r, co); end
  endtask

  task automatic test_random();
    logic [W-1:0] r, er; logic co, eco; int lat, bc;
    logic [2:0] m; logic [W-1:0] a, b; logic ci;
    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(7, 0)); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      if (i < 4) a = (i < 2) ? '1 : '0;
      ref_op(m, a, b, ci, er, eco);
      exp_q.push_back(er);
      do_op(m, a, b, ci, r, co, lat, bc);
      er = exp_q.pop_front();
      n_cmp++; if ({r, co} !== {er, eco} || lat != WORDS + 1)
        begin n_err++; $display("FAIL rand%0d m=%b a=%h b=%h ci=%b got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                                i, m, a, b, ci, r, co, lat, er, eco, WORDS + 1); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] r; logic co; int lat, bc;
    lat = 0;
    @(negedge clk);
    start = 1'b1; mode = 3'b000; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; mode = 3'b001; end
      if (c == 3) start = 1'b0;
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    n_cmp++; if (lat != WORDS + 1) begin n_err++; $display("FAIL ign_latency got=%0d exp=%0d", lat, WORDS + 1); end
    start = 1'b1; mode = 3'b010; op_a = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_done_start got busy=%b exp=0", busy); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ign_idle got=%b%b exp=00", busy, done); end
    n_cmp++; if (result !== 16'h2345) begin n_err++; $display("FAIL ign_result got=%h exp=2345", result); end
    do_op(3'b011, 16'h00F0, 16'h0F00, 1'b0, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'h0FF0, 1'b0}) begin n_err++; $display("FAIL ign_next got=%h/%b exp=0ff0/0", r, co); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; logic co; int lat, bc, seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; mode = 3'b000; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done, cout} !== 3'b000 || result !== '0)
      begin n_err++; $display("FAIL mid_reset got busy=%b done=%b cout=%b res=%h exp=0", busy, done, cout, result); end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
    do_op(3'b000, 16'h0003, 16'h0004, 1'b0, r, co, lat, bc);
    n_cmp++; if ({r, co} !== {16'h0007, 1'b0}) begin n_err++; $display("FAIL mid_after got=%h/%b exp=0007/0", r, co); end
  endtask

  task automatic test_back_to_back();
    int d[3]; int nd;
    nd = 0;
    @(negedge clk);
    start = 1'b1; mode = 3'b000; op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b1;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(negedge clk);
      if (done) begin
        d[nd] = c; nd++;
        n_cmp++; if (result !== 16'h1011) begin n_err++; $display("FAIL b2b_result got=%h exp=1011", result); end
      end
    end
    start = 1'b0;
    n_cmp++; if (nd != 3 || (d[1] - d[0]) != WORDS + 2 || (d[2] - d[1]) != WORDS + 2)
      begin n_err++; $display("FAIL b2b_spacing got n=%0d gaps=%0d,%0d exp 3 gaps=%0d", nd, d[1] - d[0], d[2] - d[1], WORDS + 2); end
    repeat (WORDS + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_inc_dec();
    test_logic();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
